// File: rtl/lsu_mem_port.sv
// Load/store unit: single outstanding transaction on a req/gnt/rvalid data bus,
// with byte-enable/lane generation, load extension and a REQ+WAIT timeout.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_mem_write,
    input  logic        ctrl_mem2reg,
    input  logic [2:0]  ctrl_word_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LP_TLAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_size;
    logic          r_we;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;

    logic          w_req;
    logic          w_illegal;
    logic          w_timeout;
    logic          w_in_req;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_ext;

    assign w_req     = ctrl_mem_write | ctrl_mem2reg;
    assign w_timeout = (r_cnt == LP_TLAST);
    assign w_in_req  = (r_state == S_REQ);

    // Legality is judged on the live inputs so the IDLE cycle can branch straight to ERR.
    always_comb begin
        w_illegal = 1'b0;
        if (ctrl_mem_write && ctrl_mem2reg) begin
            w_illegal = 1'b1;
        end else if (ctrl_mem_write) begin
            case (ctrl_word_size)
                3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
                default:                w_illegal = 1'b1;
            endcase
        end else begin
            case (ctrl_word_size)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                default:                                w_illegal = 1'b1;
            endcase
        end
        case (ctrl_word_size[1:0])
            2'b01:   if (addr[0]) w_illegal = 1'b1;
            2'b10:   if (addr[1:0] != 2'b00) w_illegal = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_req) w_next = w_illegal ? S_ERR : S_REQ;
            S_REQ: begin
                if (w_timeout)    w_next = S_ERR;
                else if (bus_gnt) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus_rvalid)     w_next = S_DONE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
            else                                      r_cnt <= '0;
            if (r_state == S_IDLE && w_req) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_size  <= ctrl_word_size;
                r_we    <= ctrl_mem_write;
            end
        end
    end

    always_comb begin
        case (r_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = bus_rdata[7:0];
            2'b01:   w_byte = bus_rdata[15:8];
            2'b10:   w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_size)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == S_WAIT && bus_rvalid && !r_we) begin
            r_rdata <= w_load_ext;
        end
    end

    // Bus fields are only driven while a request is presented; idle cycles show zeros.
    assign bus_req   = w_in_req;
    assign bus_we    = w_in_req & r_we;
    assign bus_addr  = w_in_req ? {r_addr[31:2], 2'b00} : '0;
    assign bus_be    = w_in_req ? w_be : '0;
    assign bus_wdata = w_in_req ? w_wdata : '0;

    assign lsu_busy  = (r_state == S_IDLE && w_req) || r_state == S_REQ || r_state == S_WAIT;
    assign lsu_done  = (r_state == S_DONE) || (r_state == S_ERR);
    assign lsu_err   = (r_state == S_ERR);
    assign lsu_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed spec scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_lsu_mem_port;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_mem_write = 1'b0;
    logic        ctrl_mem2reg = 1'b0;
    logic [2:0]  ctrl_word_size = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        lsu_busy, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_rdata = '0;

    lsu_mem_port #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_mem_write(ctrl_mem_write), .ctrl_mem2reg(ctrl_mem2reg),
        .ctrl_word_size(ctrl_word_size), .addr(addr), .wdata(wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
        .lsu_rdata(lsu_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] sz);
        return 1 << sz[1:0];
    endfunction

    function automatic bit m_legal(input logic we, input logic ld, input logic [2:0] sz,
                                   input logic [31:0] a);
        if (we && ld) return 0;
        if (we && !(sz == 0 || sz == 1 || sz == 2)) return 0;
        if (ld && !(sz == 0 || sz == 1 || sz == 2 || sz == 4 || sz == 5)) return 0;
        return (a % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(sz)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % nbytes(sz)))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] mem);
        logic [31:0] v, mask;
        int n;
        n = nbytes(sz);
        if (n == 4) return mem;
        mask = (32'd1 << (8 * n)) - 1;
        v = (mem >> (8 * (a % 4))) & mask;
        if (sz[2] == 1'b0 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- transaction driver with inline checks ----------------
    task automatic do_txn(input string name, input logic we, input logic ld,
                          input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] mem, input int gd, input int rd);
        bit legal, done, exp_err;
        int req_n, wait_n, exp_cycle, exp_req;
        logic [31:0] exp_rd;
        legal = m_legal(we, ld, sz, a);
        done = 0; req_n = 0; wait_n = 0;
        if (!legal) begin
            exp_err = 1; exp_cycle = 1; exp_req = 0;
        end else if (gd + rd + 2 > T) begin
            exp_err = 1; exp_cycle = T + 1; exp_req = (gd + 1 < T) ? gd + 1 : T;
        end else begin
            exp_err = 0; exp_cycle = gd + rd + 3; exp_req = gd + 1;
        end
        exp_rd = (legal && !exp_err && ld) ? m_load(sz, a, mem) : model_rdata;

        @(negedge clk);
        ctrl_mem_write = we; ctrl_mem2reg = ld; ctrl_word_size = sz;
        addr = a; wdata = wd; bus_rdata = mem;
        #1;
        tests++;
        if (lsu_busy !== 1'b1) begin
            fails++; $display("FAIL %s busy_idle: got %b want 1", name, lsu_busy);
        end
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (bus_req) begin
                req_n++;
                tests++;
                if (bus_we !== we || bus_addr !== {a[31:2], 2'b00} || bus_be !== m_be(sz, a)
                    || (we && bus_wdata !== m_wdata(sz, wd))) begin
                    fails++;
                    $display("FAIL %s bus_fields c%0d: we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                             name, c, bus_we, bus_addr, bus_be, bus_wdata, we,
                             {a[31:2], 2'b00}, m_be(sz, a), m_wdata(sz, wd));
                end
            end else if (req_n > 0 && lsu_busy) begin
                wait_n++;
            end
            if (lsu_done) begin
                done = 1;
                tests++;
                if (c !== exp_cycle || lsu_err !== exp_err || lsu_rdata !== exp_rd
                    || lsu_busy !== 1'b0 || req_n !== exp_req) begin
                    fails++;
                    $display("FAIL %s completion: cycle=%0d err=%b rdata=%h busy=%b reqs=%0d want cycle=%0d err=%b rdata=%h busy=0 reqs=%0d",
                             name, c, lsu_err, lsu_rdata, lsu_busy, req_n,
                             exp_cycle, exp_err, exp_rd, exp_req);
                end
                model_rdata = exp_rd;
                ctrl_mem_write = 0; ctrl_mem2reg = 0;
            end else begin
                tests++;
                if (lsu_busy !== 1'b1) begin
                    fails++; $display("FAIL %s busy_hold c%0d: got %b want 1", name, c, lsu_busy);
                end
            end
            bus_gnt    = bus_req && (req_n == gd + 1);
            bus_rvalid = !bus_req && req_n > 0 && (wait_n == rd + 1);
        end
        bus_gnt = 0; bus_rvalid = 0;
        ctrl_mem_write = 0; ctrl_mem2reg = 0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s no_done: lsu_done never seen within 40 cycles, want cycle %0d",
                     name, exp_cycle);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        #1;
        tests++;
        if ({lsu_busy, lsu_done, lsu_err, bus_req, bus_we} !== 5'b0 || lsu_rdata !== 0
            || bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b req=%b rdata=%h want all 0",
                     lsu_busy, lsu_done, lsu_err, bus_req, lsu_rdata);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load_ext;
        do_txn("lb_103",  0, 1, 3'b000, 32'h103, 0, 32'h80FF7F01, 0, 0);
        do_txn("lbu_103", 0, 1, 3'b100, 32'h103, 0, 32'h80FF7F01, 0, 0);
        do_txn("lh_100",  0, 1, 3'b001, 32'h100, 0, 32'h80FF7F01, 0, 0);
        do_txn("lhu_102", 0, 1, 3'b101, 32'h102, 0, 32'h80FF7F01, 1, 1);
        do_txn("lw_100",  0, 1, 3'b010, 32'h100, 0, 32'h80FF7F01, 0, 2);
    endtask

    task automatic test_store_lanes;
        do_txn("sh_102", 1, 0, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 0);
        do_txn("sb_101", 1, 0, 3'b000, 32'h101, 32'h000000A5, 0, 0, 0);
        do_txn("sw_200", 1, 0, 3'b010, 32'h200, 32'hCAFEF00D, 0, 2, 0);
    endtask

    task automatic test_misaligned;
        do_txn("lw_102_mis",  0, 1, 3'b010, 32'h102, 0, 32'h11111111, 0, 0);
        do_txn("both_ctrl",   1, 1, 3'b010, 32'h100, 0, 32'h11111111, 0, 0);
        do_txn("store_sz100", 1, 0, 3'b100, 32'h100, 0, 32'h11111111, 0, 0);
        do_txn("lh_101_mis",  0, 1, 3'b001, 32'h101, 0, 32'h11111111, 0, 0);
        do_txn("load_sz011",  0, 1, 3'b011, 32'h100, 0, 32'h11111111, 0, 0);
    endtask

    task automatic test_wait_states;
        do_txn("wait_5_2", 0, 1, 3'b010, 32'h340, 0, 32'hDEADBEEF, 5, 2);
    endtask

    task automatic test_timeout;
        do_txn("timeout_nognt", 0, 1, 3'b010, 32'h100, 0, 32'h12345678, 1000, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_rvalid = 1;
            #1;
            tests++;
            if (lsu_done !== 1'b0 || lsu_busy !== 1'b0) begin
                fails++;
                $display("FAIL stray_rvalid_%0d: done=%b busy=%b want 0 0", i, lsu_done, lsu_busy);
            end
        end
        @(negedge clk);
        bus_rvalid = 0;
        do_txn("timeout_in_wait", 1, 0, 3'b010, 32'h100, 32'h1, 0, 0, 1000);
    endtask

    task automatic test_reset_mid;
        bit in_wait;
        in_wait = 0;
        @(negedge clk);
        ctrl_mem2reg = 1; ctrl_word_size = 3'b010; addr = 32'h100; bus_rdata = 32'h55AA55AA;
        for (int c = 0; c < 10 && !in_wait; c++) begin
            @(negedge clk);
            bus_gnt = bus_req;
            if (!bus_req && lsu_busy && c > 1) in_wait = 1;
        end
        bus_gnt = 0;
        rst_n = 0; ctrl_mem2reg = 0;
        #1;
        tests++;
        if (!in_wait || {lsu_busy, lsu_done, lsu_err, bus_req, bus_we} !== 5'b0
            || lsu_rdata !== 0 || bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0) begin
            fails++;
            $display("FAIL reset_mid: reached_wait=%b busy=%b done=%b err=%b req=%b rdata=%h want wait=1 and all 0",
                     in_wait, lsu_busy, lsu_done, lsu_err, bus_req, lsu_rdata);
        end
        model_rdata = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            bus_rvalid = 1;
            @(negedge clk);
            tests++;
            if (lsu_done !== 1'b0) begin
                fails++; $display("FAIL reset_mid_rvalid_%0d: done=%b want 0", i, lsu_done);
            end
        end
        bus_rvalid = 0;
        do_txn("lw_after_reset", 0, 1, 3'b010, 32'h100, 0, 32'h55AA55AA, 0, 0);
    endtask

    task automatic test_random;
        logic we, ld;
        logic [2:0] sz;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:          begin we = 1; ld = 1; end
                1, 2, 3, 4: begin we = 0; ld = 1; end
                default:    begin we = 1; ld = 0; end
            endcase
            if ($urandom_range(0, 4) == 0) sz = 3'($urandom_range(0, 7));
            else if (we)                   sz = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: sz = 3'b000; 1: sz = 3'b001; 2: sz = 3'b010; 3: sz = 3'b100;
                    default: sz = 3'b101;
                endcase
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            do_txn($sformatf("rand%0d", n), we, ld, sz, a, $urandom, $urandom,
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset;
        test_load_ext;
        test_store_lanes;
        test_misaligned;
        test_wait_states;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
